// File: rtl/coin_vend_fsm.sv
// Coin-accumulating vending controller: collects N/D/Q credit, dispenses at PRICE,
// and pays back excess or cancelled credit as a back-to-back train of N_VAL change pulses.
module coin_vend_fsm #(
    parameter int PRICE    = 15,
    parameter int N_VAL    = 5,
    parameter int D_VAL    = 10,
    parameter int Q_VAL    = 25,
    parameter int CREDIT_W = 6
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                N,
    input  logic                D,
    input  logic                Q,
    input  logic                Cancel,
    output logic                Dispense,
    output logic                Change,
    output logic                Reject,
    output logic                Err,
    output logic                Busy,
    output logic [CREDIT_W-1:0] Credit
);

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } state_t;

    state_t              state;
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] change;
    logic                reject;
    logic                err;

    logic [1:0]          coin_cnt;
    logic                coin_single;
    logic                coin_multi;
    logic [CREDIT_W-1:0] coin_value;
    logic [CREDIT_W-1:0] sum;

    assign coin_cnt    = 2'(N) + 2'(D) + 2'(Q);
    assign coin_single = (coin_cnt == 2'd1);
    assign coin_multi  = (coin_cnt > 2'd1);

    always_comb begin
        coin_value = '0;
        if (N)
            coin_value = CREDIT_W'(N_VAL);
        else if (D)
            coin_value = CREDIT_W'(D_VAL);
        else if (Q)
            coin_value = CREDIT_W'(Q_VAL);
    end

    assign sum = credit + coin_value;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= COLLECT;
            credit <= '0;
            change <= '0;
            reject <= 1'b0;
            err    <= 1'b0;
        end else begin
            err    <= coin_multi;
            // A coin arriving alongside Cancel, or while busy, is handed straight back.
            reject <= coin_single && ((state != COLLECT) || Cancel);
            case (state)
                COLLECT: begin
                    if (Cancel) begin
                        if (credit != '0) begin
                            change <= credit;
                            credit <= '0;
                            state  <= CHANGE;
                        end
                    end else if (coin_single) begin
                        if (sum >= CREDIT_W'(PRICE)) begin
                            change <= sum - CREDIT_W'(PRICE);
                            credit <= '0;
                            state  <= DISPENSE;
                        end else begin
                            credit <= sum;
                        end
                    end
                end
                DISPENSE: begin
                    state <= (change != '0) ? CHANGE : COLLECT;
                end
                CHANGE: begin
                    change <= change - CREDIT_W'(N_VAL);
                    if (change <= CREDIT_W'(N_VAL))
                        state <= COLLECT;
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

    assign Dispense = (state == DISPENSE);
    assign Change   = (state == CHANGE);
    assign Busy     = (state != COLLECT);
    assign Reject   = reject;
    assign Err      = err;
    assign Credit   = credit;

endmodule

// File: tb/tb_coin_vend_fsm.sv
// Bench for coin_vend_fsm: directed vector table, reset-during-change sequence,
// and randomized coin traffic against a schedule-based reference model.
module tb_coin_vend_fsm;

    localparam int PRICE    = 15;
    localparam int N_VAL    = 5;
    localparam int D_VAL    = 10;
    localparam int Q_VAL    = 25;
    localparam int CREDIT_W = 6;

    logic                clk = 1'b0;
    logic                rst;
    logic                n, d, q, cancel;
    logic                dispense, change, reject, err, busy;
    logic [CREDIT_W-1:0] credit;

    int total = 0;
    int bad   = 0;

    coin_vend_fsm #(
        .PRICE(PRICE), .N_VAL(N_VAL), .D_VAL(D_VAL), .Q_VAL(Q_VAL), .CREDIT_W(CREDIT_W)
    ) dut (
        .Clock(clk), .Reset(rst), .N(n), .D(d), .Q(q), .Cancel(cancel),
        .Dispense(dispense), .Change(change), .Reject(reject), .Err(err),
        .Busy(busy), .Credit(credit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic n, d, q, c;
        logic disp, chg, rej, err, busy;
        int   credit;
    } vec_t;

    vec_t vecs[$];

    function automatic int packo(logic a, logic b, logic c, logic e, logic f, int cr);
        return (int'({a, b, c, e, f}) << CREDIT_W) | cr;
    endfunction

    function automatic int dut_out();
        return packo(dispense, change, reject, err, busy, int'(credit));
    endfunction

    task automatic check(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h (disp,chg,rej,err,busy|credit)",
                     name, act, exp);
        end
    endtask

    task automatic add(logic vn, logic vd, logic vq, logic vc,
                       logic ed, logic ec, logic er, logic ee, logic eb, int ecr);
        vec_t v;
        v.n = vn; v.d = vd; v.q = vq; v.c = vc;
        v.disp = ed; v.chg = ec; v.rej = er; v.err = ee; v.busy = eb; v.credit = ecr;
        vecs.push_back(v);
    endtask

    task automatic step(logic vn, logic vd, logic vq, logic vc);
        @(negedge clk);
        n = vn; d = vd; q = vq; cancel = vc;
        @(posedge clk);
        #1;
    endtask

    // Reference model: credit as an integer and a queue of future busy cycles
    // (1 = dispense cycle, 2 = change pulse); cur is what the outputs show now.
    int m_credit;
    int m_cur;
    int m_rest[$];

    task automatic model_step(logic vn, logic vd, logic vq, logic vc, output int exp);
        int cnt, val, refund;
        logic single, multi, is_busy, rj;
        cnt    = int'(vn) + int'(vd) + int'(vq);
        single = (cnt == 1);
        multi  = (cnt > 1);
        val    = vn ? N_VAL : (vd ? D_VAL : Q_VAL);
        is_busy = (m_cur != 0);
        rj     = single && (is_busy || vc);
        if (is_busy) begin
            m_cur = (m_rest.size() > 0) ? m_rest.pop_front() : 0;
        end else begin
            m_cur = 0;
            m_rest.delete();
            if (vc) begin
                for (int i = 0; i < m_credit / N_VAL; i++) m_rest.push_back(2);
                m_credit = 0;
            end else if (single) begin
                if (m_credit + val >= PRICE) begin
                    refund = m_credit + val - PRICE;
                    m_rest.push_back(1);
                    for (int i = 0; i < refund / N_VAL; i++) m_rest.push_back(2);
                    m_credit = 0;
                end else begin
                    m_credit = m_credit + val;
                end
            end
            if (m_rest.size() > 0) m_cur = m_rest.pop_front();
        end
        exp = packo(m_cur == 1, m_cur == 2, rj, multi, m_cur != 0, m_credit);
    endtask

    initial begin
        int exp, r;
        logic rn, rd, rq, rc;

        //   N D Q C   disp chg rej err busy credit
        add(1,0,0,0,  0,0,0,0,0, 5);
        add(1,0,0,0,  0,0,0,0,0, 10);
        add(1,0,0,0,  1,0,0,0,1, 0);
        add(0,0,0,0,  0,0,0,0,0, 0);
        add(0,1,0,0,  0,0,0,0,0, 10);
        add(0,1,0,0,  1,0,0,0,1, 0);
        add(0,0,0,0,  0,1,0,0,1, 0);
        add(0,0,0,0,  0,0,0,0,0, 0);
        add(0,0,1,0,  1,0,0,0,1, 0);
        add(0,0,0,0,  0,1,0,0,1, 0);
        add(1,0,0,0,  0,1,1,0,1, 0);
        add(0,0,0,0,  0,0,0,0,0, 0);
        add(1,0,0,0,  0,0,0,0,0, 5);
        add(0,0,0,1,  0,1,0,0,1, 0);
        add(0,0,0,0,  0,0,0,0,0, 0);
        add(0,0,0,1,  0,0,0,0,0, 0);
        add(1,0,0,0,  0,0,0,0,0, 5);
        add(1,1,0,0,  0,0,0,1,0, 5);
        add(0,0,0,0,  0,0,0,0,0, 5);
        add(1,0,0,1,  0,1,1,0,1, 0);
        add(0,0,0,0,  0,0,0,0,0, 0);
        add(0,1,0,1,  0,0,1,0,0, 0);
        add(1,1,1,0,  0,0,0,1,0, 0);
        add(0,0,0,0,  0,0,0,0,0, 0);

        rst = 1'b1; n = 0; d = 0; q = 0; cancel = 0;
        #12;
        check("reset_state", dut_out(), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].c);
            check($sformatf("vec%0d", i), dut_out(),
                  packo(vecs[i].disp, vecs[i].chg, vecs[i].rej, vecs[i].err,
                        vecs[i].busy, vecs[i].credit));
        end

        // Reset asserted asynchronously in the middle of the first change pulse.
        step(0,0,1,0);
        check("rst_seq_dispense", dut_out(), packo(1,0,0,0,1,0));
        step(0,0,0,0);
        check("rst_seq_change", dut_out(), packo(0,1,0,0,1,0));
        #2 rst = 1'b1;
        #1;
        check("rst_mid_change", dut_out(), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1,0,0,0);
        check("rst_fresh_n", dut_out(), packo(0,0,0,0,0,5));
        step(0,0,0,0);
        check("rst_no_leftover", dut_out(), packo(0,0,0,0,0,5));

        // Randomized traffic from a clean reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_credit = 0;
        m_cur = 0;
        m_rest.delete();
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            rn = 0; rd = 0; rq = 0; rc = 0;
            if (r < 18)      rn = 1;
            else if (r < 30) rd = 1;
            else if (r < 38) rq = 1;
            else if (r < 42) begin
                rn = 1'($urandom_range(0, 1)); rd = 1; rq = ~rn | 1'($urandom_range(0, 1));
            end
            else if (r < 50) rc = 1;
            else if (r < 54) begin
                rc = 1; rn = (r < 52); rd = (r >= 52);
            end
            model_step(rn, rd, rq, rc, exp);
            step(rn, rd, rq, rc);
            check($sformatf("rand%0d", i), dut_out(), exp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
